// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle controller (master) and the RV32I datapath (slave).
interface multicycle_control_if #(
  parameter int RETIRE_W = 32
);
  logic [6:0]          OPCODE;
  logic [2:0]          FUNCT3;
  logic                FUNCT7_5;
  logic                ZERO;
  logic                PC_WRITE;
  logic                OLDPC_WRITE;
  logic                IR_WRITE;
  logic                REG_WRITE;
  logic                RW_MEM;
  logic                MEM_TO_REG;
  logic [1:0]          ALU_SRC_A;
  logic [1:0]          ALU_SRC_B;
  logic                PC_SRC;
  logic [3:0]          ALU_CTRL;
  logic [2:0]          STATE;
  logic [RETIRE_W-1:0] RETIRED;
  logic                HALTED;

  modport master (
    input  OPCODE, FUNCT3, FUNCT7_5, ZERO,
    output PC_WRITE, OLDPC_WRITE, IR_WRITE, REG_WRITE, RW_MEM, MEM_TO_REG,
           ALU_SRC_A, ALU_SRC_B, PC_SRC, ALU_CTRL, STATE, RETIRED, HALTED
  );

  modport slave (
    output OPCODE, FUNCT3, FUNCT7_5, ZERO,
    input  PC_WRITE, OLDPC_WRITE, IR_WRITE, REG_WRITE, RW_MEM, MEM_TO_REG,
           ALU_SRC_A, ALU_SRC_B, PC_SRC, ALU_CTRL, STATE, RETIRED, HALTED
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle sequencer for an RV32I subset: Moore FSM driving datapath enables and mux selects,
// with a retired-instruction counter and optional halt on illegal opcodes.
module multicycle_control #(
  parameter int RETIRE_W     = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input logic                 CLK,
  input logic                 RST,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q;
  logic                retire;

  logic pc_write, oldpc_write, ir_write, reg_write, rw_mem, mem_to_reg, pc_src;
  logic [1:0] alu_src_a, alu_src_b;
  logic [3:0] alu_ctrl;

  logic is_r, is_i, is_br, is_ld, is_st, legal, br_taken;

  assign is_r  = (bus.OPCODE == 7'b0110011);
  assign is_i  = (bus.OPCODE == 7'b0010011);
  assign is_br = (bus.OPCODE == 7'b1100011);
  assign is_ld = (bus.OPCODE == 7'b0000011);
  assign is_st = (bus.OPCODE == 7'b0100011);
  // Only word-sized memory accesses are supported; byte/half variants count as illegal.
  assign legal = is_r | is_i | is_br | ((is_ld | is_st) & (bus.FUNCT3 == 3'b010));
  assign br_taken = ((bus.FUNCT3 == 3'b000) &  bus.ZERO) |
                    ((bus.FUNCT3 == 3'b001) & ~bus.ZERO);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    retire      = 1'b0;
    pc_write    = 1'b0;
    oldpc_write = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    rw_mem      = 1'b0;
    mem_to_reg  = 1'b0;
    pc_src      = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_ctrl    = 4'b0000;
    case (state_q)
      S_FETCH: begin
        ir_write    = 1'b1;
        oldpc_write = 1'b1;
        pc_write    = 1'b1;
        alu_src_b   = 2'b01;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b11;
        if (legal)             state_d = S_EXEC;
        else if (ILLEGAL_HALT) state_d = S_HALT;
        else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a = 2'b10;
        if (is_r) begin
          alu_ctrl = {bus.FUNCT7_5, bus.FUNCT3};
          state_d  = S_WB;
        end else if (is_i) begin
          // IR[30] is part of the immediate except for the shift-right pair.
          alu_src_b = 2'b10;
          alu_ctrl  = (bus.FUNCT3 == 3'b101) ? {bus.FUNCT7_5, bus.FUNCT3} : {1'b0, bus.FUNCT3};
          state_d   = S_WB;
        end else if (is_ld | is_st) begin
          alu_src_b = 2'b10;
          state_d   = S_MEM;
        end else if (is_br) begin
          alu_ctrl = 4'b1000;
          pc_src   = 1'b1;
          pc_write = br_taken;
          retire   = 1'b1;
        end
      end
      S_MEM: begin
        if (is_st) begin
          rw_mem = 1'b1;
          retire = 1'b1;
        end else if (is_ld) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        retire     = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset suppresses every write in the cycle it is asserted.
  assign bus.PC_WRITE    = pc_write    & ~RST;
  assign bus.OLDPC_WRITE = oldpc_write & ~RST;
  assign bus.IR_WRITE    = ir_write    & ~RST;
  assign bus.REG_WRITE   = reg_write   & ~RST;
  assign bus.RW_MEM      = rw_mem      & ~RST;
  assign bus.MEM_TO_REG  = mem_to_reg;
  assign bus.PC_SRC      = pc_src;
  assign bus.ALU_SRC_A   = alu_src_a;
  assign bus.ALU_SRC_B   = alu_src_b;
  assign bus.ALU_CTRL    = alu_ctrl;
  assign bus.STATE       = state_q;
  assign bus.RETIRED     = retired_q;
  assign bus.HALTED      = (state_q == S_HALT);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequences the RV32I-subset datapath (instruction memory, register file, sign extension, ALU, data memory) as a multicycle machine.
- Executes each instruction over 3–5 clock cycles.
- Drives every write enable, mux select and ALU control code from a state register and the latched instruction fields.
- Counts retired instructions and halts on an illegal opcode.

Parameters:
- RETIRE_W, 32: width of the retired-instruction counter.
- ILLEGAL_HALT, 1: 1 = an illegal opcode enters HALT; 0 = an illegal opcode retires as a NOP.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- OPCODE  in  7  IR[6:0]; valid from DECODE onward.
- FUNCT3  in  3  IR[14:12].
- FUNCT7_5  in  1  IR[30].
- ZERO  in  1  ALU zero flag.
- PC_WRITE  out  1  unconditional PC load.
- OLDPC_WRITE  out  1  capture the current PC into OldPC.
- IR_WRITE  out  1  load the instruction register.
- REG_WRITE  out  1  register file write enable.
- RW_MEM  out  1  data memory direction; 0 = read, 1 = write.
- MEM_TO_REG  out  1  writeback source; 0 = ALUOut, 1 = memory data register.
- ALU_SRC_A  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- ALU_SRC_B  out  2  00 = RD2, 01 = constant 4, 10 = sign-extended immediate, 11 = branch offset.
- PC_SRC  out  1  0 = ALU result, 1 = ALUOut (branch target).
- ALU_CTRL  out  4  {IR[30], funct3} style code to the ALU control decoder.
- STATE  out  3  current state, for debug.
- RETIRED  out  RETIRE_W  retired-instruction count.
- HALTED  out  1  high while in HALT.

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5. Codes 6–7 return to FETCH on the next edge.
- Reset:
  - RST high on an edge sets STATE = FETCH, RETIRED = 0 and HALTED = 0.
  - While RST is high, every enable output (PC_WRITE, OLDPC_WRITE, IR_WRITE, REG_WRITE, RW_MEM) is forced to 0.
  - RST overrides every state, including HALT and mid-instruction. No write is issued in the cycle RST is high.
- Outputs are Moore functions of STATE plus the instruction fields. Any enable not listed for a state is 0.
- FETCH:
  - Asserts IR_WRITE, OLDPC_WRITE and PC_WRITE.
  - ALU_SRC_A = 00, ALU_SRC_B = 01, ALU_CTRL = 0000, PC_SRC = 0.
  - Next state: DECODE.
- DECODE:
  - Computes the branch target: ALU_SRC_A = 01, ALU_SRC_B = 11, ALU_CTRL = 0000.
  - Next state by opcode:
    - 0110011 (R-type), 0010011 (I-type ALU), 1100011 (branch) → EXEC.
    - 0000011 (load) or 0100011 (store) with FUNCT3 = 010 → EXEC.
    - Any other opcode, or a load/store with FUNCT3 ≠ 010 → HALT if ILLEGAL_HALT = 1; otherwise → FETCH and the instruction retires.
- EXEC by class:
  - R-type: ALU_SRC_A = 10, ALU_SRC_B = 00, ALU_CTRL = {FUNCT7_5, FUNCT3}; next WB.
  - I-type ALU: ALU_SRC_B = 10. ALU_CTRL = {FUNCT7_5, FUNCT3} only when FUNCT3 = 101 (SRAI/SRLI); otherwise {0, FUNCT3}. Next WB.
  - Load/store: ALU_SRC_A = 10, ALU_SRC_B = 10, ALU_CTRL = 0000; next MEM.
  - Branch:
    - ALU_SRC_A = 10, ALU_SRC_B = 00, ALU_CTRL = 1000 (subtract), PC_SRC = 1.
    - PC_WRITE = 1 only if (FUNCT3 = 000 and ZERO = 1) or (FUNCT3 = 001 and ZERO = 0).
    - Any other FUNCT3 is never taken.
    - Next FETCH; the branch retires.
- MEM:
  - Load: RW_MEM = 0; next WB.
  - Store: RW_MEM = 1 for exactly one cycle; next FETCH; the store retires.
- WB:
  - REG_WRITE = 1; MEM_TO_REG = 1 for load, 0 otherwise.
  - Next FETCH; the instruction retires.
- Latency from FETCH to the next FETCH:
  - R-type and I-type ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Illegal opcode as NOP: 2 cycles.
- RETIRED:
  - Increments by 1 on the edge leaving a retiring state toward FETCH.
  - Wraps from all-ones to 0 silently.
  - A reset on the same edge wins, so the result is 0.
- HALT:
  - All enables 0, HALTED = 1, RETIRED frozen.
  - Only RST exits HALT.
- REG_WRITE and RW_MEM are never both 1, and each stays high for at most one cycle per instruction.

Test Plan:
- Reset, then `add x3,x1,x2` (0x002081B3): STATE sequence 0,1,2,4,0. ALU_CTRL = 0000 in EXEC; REG_WRITE high only in WB; RETIRED = 1 after 4 cycles.
- `lw x5,8(x0)` (0x00802283) followed by `sw x5,12(x0)` (0x00502623): 5 + 4 cycles. RW_MEM = 1 in exactly one cycle (store MEM); MEM_TO_REG = 1 in load WB; RETIRED = 2.
- `beq` with ZERO = 1: PC_WRITE = 1 in EXEC with PC_SRC = 1. `bne` with ZERO = 1: PC_WRITE = 0 in EXEC. Each takes 3 cycles.
- Opcode 0x7F with ILLEGAL_HALT = 1: STATE = 5 and HALTED = 1 from the cycle after DECODE, holding 20 cycles with RETIRED unchanged. RST then gives STATE = 0, HALTED = 0, RETIRED = 0.
- `srai` (FUNCT3 = 101, IR[30] = 1): ALU_CTRL = 1101 in EXEC. `addi` with IR[30] = 1: ALU_CTRL = 0000.
- RST asserted during load MEM: no REG_WRITE on any later cycle for that load; the next cycle has STATE = 0. Separately, preload RETIRED = 0xFFFFFFFF via force; after one retire RETIRED = 0.
